// File: rtl/alu_pkg.sv
// alu_pkg: shared width, opcode/state enums, flag indices and the single-cycle evaluator
package alu_pkg;
  localparam int WIDTH = 16;
  localparam int F_N = 3;
  localparam int F_Z = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
    OP_SHL, OP_SHR, OP_ASR, OP_PASS, OP_INC, OP_MUL
  } op_t;
  typedef enum logic {S_IDLE, S_MUL} state_t;
  // Returns {flags, result}; reserved opcodes (and MUL here) give all zeros.
  function automatic logic [WIDTH+3:0] alu_eval(logic [3:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    logic [WIDTH-1:0] r;
    logic [3:0] f;
    s = '0;
    r = '0;
    f = '0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[WIDTH-1:0];
        f[F_C] = s[WIDTH];
        f[F_V] = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        r = s[WIDTH-1:0];
        f[F_C] = s[WIDTH];
        f[F_V] = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: r = a & b;
      OP_OR: r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~b;
      OP_SHL: begin
        r = {a[WIDTH-2:0], 1'b0};
        f[F_C] = a[WIDTH-1];
      end
      OP_SHR: begin
        r = {1'b0, a[WIDTH-1:1]};
        f[F_C] = a[0];
      end
      OP_ASR: begin
        r = {a[WIDTH-1], a[WIDTH-1:1]};
        f[F_C] = a[0];
      end
      OP_PASS: r = b;
      OP_INC: begin
        s = {1'b0, b} + {{WIDTH{1'b0}}, 1'b1};
        r = s[WIDTH-1:0];
        f[F_C] = s[WIDTH];
      end
      default: return '0;
    endcase
    f[F_N] = r[WIDTH-1];
    f[F_Z] = r == '0;
    return {f, r};
  endfunction
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 16-iteration shift-add multiplier; last flags the final iteration, prod its sum
module alu_mul_seq import alu_pkg::*; (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 last,
  output logic [2*WIDTH-1:0]   prod
);
  state_t state;
  logic [3:0] cnt;
  logic [2*WIDTH-1:0] acc, a_sh;
  logic [WIDTH-1:0] b_sh;
  assign prod = acc + (b_sh[0] ? a_sh : '0);
  assign last = state == S_MUL && cnt == 4'd15;
  always_ff @(posedge clk)
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      acc <= '0;
      a_sh <= '0;
      b_sh <= '0;
      busy <= 1'b0;
    end else if (state == S_IDLE && start) begin
      state <= S_MUL;
      cnt <= '0;
      acc <= '0;
      a_sh <= {{WIDTH{1'b0}}, a};
      b_sh <= b;
      busy <= 1'b1;
    end else if (state == S_MUL) begin
      acc <= prod;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt <= cnt + 4'd1;
      state <= last ? S_IDLE : S_MUL;
      busy <= !last;
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle 16-bit ALU driving Z's from_ALU input
// Define ALU_MUL_EN to compile in the sequential multiplier for opcode 11.
module alu_mc import alu_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] y_val,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [3:0]       alu_op,
  input  logic             start,
  output logic [WIDTH-1:0] from_ALU,
  output logic             busy,
  output logic             done,
  output logic [3:0]       flags
);
  logic mul_op, mul_last;
  logic [2*WIDTH-1:0] mul_prod;
  logic [3:0] mul_flags;
`ifdef ALU_MUL_EN
  assign mul_op = alu_op == OP_MUL;
  alu_mul_seq u_mul (
    .clk   (clk),
    .reset (reset),
    .start (start && mul_op),
    .a     (y_val),
    .b     (bus_in),
    .busy  (busy),
    .last  (mul_last),
    .prod  (mul_prod)
  );
`else
  assign mul_op = 1'b0;
  assign mul_last = 1'b0;
  assign mul_prod = '0;
  assign busy = 1'b0;
`endif
  assign mul_flags = {mul_prod[WIDTH-1], mul_prod[WIDTH-1:0] == '0, |mul_prod[2*WIDTH-1:WIDTH], 1'b0};
  always_ff @(posedge clk)
    if (!reset) begin
      from_ALU <= '0;
      flags <= '0;
      done <= 1'b0;
    end else if (mul_last) begin
      from_ALU <= mul_prod[WIDTH-1:0];
      flags <= mul_flags;
      done <= 1'b1;
    end else if (start && !busy && !mul_op) begin
      {flags, from_ALU} <= alu_eval(alu_op, y_val, bus_in);
      done <= 1'b1;
    end else
      done <= 1'b0;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and random checks of alu_mc against an arithmetic reference model
module tb_alu_mc;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [15:0] y_val = '0, bus_in = '0;
  logic [3:0] alu_op = '0;
  logic [15:0] from_ALU;
  logic busy, done;
  logic [3:0] flags;
  int n_cmp = 0, n_err = 0;
  bit chk_en = 1'b0;
  logic [15:0] e_res;
  logic [3:0] e_flags;
  logic e_done, e_busy;
  logic [19:0] pend;
  int left;

  alu_mc dut (
    .clk(clk), .reset(reset), .y_val(y_val), .bus_in(bus_in), .alu_op(alu_op),
    .start(start), .from_ALU(from_ALU), .busy(busy), .done(done), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] ref_op(input int op, input int a, input int b);
    int r, sa, sb, s;
    bit c, v;
    longint p;
    sa = a > 32767 ? a - 65536 : a;
    sb = b > 32767 ? b - 65536 : b;
    r = 0; c = 0; v = 0;
    case (op)
      0: begin r = a + b; c = r > 65535; s = sa + sb; v = s > 32767 || s < -32768; end
      1: begin r = a - b; c = a >= b; s = sa - sb; v = s > 32767 || s < -32768; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 65535 - b;
      6: begin r = a * 2; c = a > 32767; end
      7: begin r = a / 2; c = a % 2 == 1; end
      8: begin r = a / 2 + (a > 32767 ? 32768 : 0); c = a % 2 == 1; end
      9: r = b;
      10: begin r = b + 1; c = r > 65535; end
      11: begin
        if (!MUL_EN) return '0;
        p = longint'(a) * longint'(b);
        r = int'(p % 65536);
        c = p > 65535;
      end
      default: return '0;
    endcase
    r = r & 65535;
    return {r[15], r == 0, c, v, r[15:0]};
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      e_res = '0; e_flags = '0; e_done = 0; e_busy = 0; left = 0;
    end else begin
      e_done = 0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          {e_flags, e_res} = pend;
          e_done = 1;
          e_busy = 0;
        end
      end else if (start) begin
        if (MUL_EN && alu_op == 4'd11) begin
          pend = ref_op(int'(alu_op), int'(y_val), int'(bus_in));
          left = 16;
          e_busy = 1;
        end else begin
          {e_flags, e_res} = ref_op(int'(alu_op), int'(y_val), int'(bus_in));
          e_done = 1;
        end
      end
    end
  end

  always @(negedge clk)
    if (chk_en) begin
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
      check("from_ALU", 32'(from_ALU), 32'(e_res));
      check("flags", 32'(flags), 32'(e_flags));
    end

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    alu_op = op; y_val = a; bus_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input bit poke,
                         output int done_at, output int busy_cnt);
    issue(4'd11, a, b);
    done_at = 0; busy_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (poke && k == 5) begin alu_op = 4'd0; start = 1'b1; end
      if (poke && k == 6) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin done_at = k; break; end
    end
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] edge_v [4];
    edge_v = '{16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF};
    return ($urandom % 4 == 0) ? edge_v[$urandom % 4] : 16'($urandom);
  endfunction

  initial begin
    int done_at, busy_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_from_ALU", 32'(from_ALU), 32'h0);
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    chk_en = 1'b1;
    reset = 1'b1;
    issue(4'd0, 16'h7FFF, 16'h0001);
    @(negedge clk);
    check("add_done", 32'(done), 32'h1);
    check("add_res", 32'(from_ALU), 32'h8000);
    check("add_flags", 32'(flags), 32'b1001);
    issue(4'd1, 16'h0005, 16'h0005);
    @(negedge clk);
    check("sub_eq_res", 32'(from_ALU), 32'h0000);
    check("sub_eq_flags", 32'(flags), 32'b0110);
    issue(4'd1, 16'h0000, 16'h0001);
    @(negedge clk);
    check("sub_borrow_res", 32'(from_ALU), 32'hFFFF);
    check("sub_borrow_flags", 32'(flags), 32'b1000);
    issue(4'd8, 16'h8001, 16'h0000);
    @(negedge clk);
    check("asr_res", 32'(from_ALU), 32'hC000);
    check("asr_flags", 32'(flags), 32'b1010);
    if (MUL_EN) begin
      run_mul(16'h0123, 16'h0010, 1'b1, done_at, busy_cnt);
      check("mul1_done_at", 32'(done_at), 32'd17);
      check("mul1_busy_cycles", 32'(busy_cnt), 32'd16);
      check("mul1_res", 32'(from_ALU), 32'h1230);
      check("mul1_flags", 32'(flags), 32'b0000);
      @(negedge clk);
      check("mul1_no_queue", 32'(done), 32'h0);
      run_mul(16'h1000, 16'h0100, 1'b0, done_at, busy_cnt);
      check("mul2_done_at", 32'(done_at), 32'd17);
      check("mul2_res", 32'(from_ALU), 32'h0000);
      check("mul2_flags", 32'(flags), 32'b0110);
      issue(4'd11, 16'h00FF, 16'h00FF);
      repeat (7) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_done", 32'(done), 32'h0);
      check("midrst_res", 32'(from_ALU), 32'h0);
      check("midrst_flags", 32'(flags), 32'h0);
      reset = 1'b1;
      issue(4'd0, 16'h0002, 16'h0003);
      @(negedge clk);
      check("post_rst_add", 32'(from_ALU), 32'h0005);
      repeat (20) @(negedge clk);
      check("post_rst_idle", 32'(busy), 32'h0);
    end else begin
      issue(4'd11, 16'h0003, 16'h0004);
      @(negedge clk);
      check("nomul_done", 32'(done), 32'h1);
      check("nomul_res", 32'(from_ALU), 32'h0);
      check("nomul_flags", 32'(flags), 32'h0);
      check("nomul_busy", 32'(busy), 32'h0);
    end
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      reset = ($urandom % 97) != 0;
      start = ($urandom % 3) != 0;
      alu_op = 4'($urandom % 16);
      y_val = pick();
      bus_in = pick();
    end
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("final_idle", 32'(busy), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle 16-bit ALU sitting directly upstream of the Z register in the single-bus datapath. Takes operand A from the Y register and operand B from the bus, registers its result and status flags, and drives the Z register's `from_ALU` input. Most ops finish in one cycle; an optional shift-add multiply takes 16 iterations behind a start/busy/done handshake that the control unit uses to time `Z_in`.

## Interface
- `WIDTH`, 16, datapath width; only 16 is supported.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low; 0 on a rising edge resets the block.
- `y_val`  in  16  operand A, from the Y register.
- `bus_in`  in  16  operand B, from the shared bus.
- `alu_op`  in  4  opcode; sampled with `start`.
- `start`  in  1  begin operation; ignored while `busy`=1.
- `from_ALU`  out  16  registered result, feeds the Z register.
- `busy`  out  1  multi-cycle operation in progress.
- `done`  out  1  one-cycle pulse: `from_ALU` and flags updated this cycle.
- `flags`  out  4  {N, Zf, C, V}, registered with the result.

## Operation
- Opcodes:
  - 0 ADD: A+B
  - 1 SUB: A-B, computed as A+~B+1
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT: ~B
  - 6 SHL: A<<1
  - 7 SHR: logical A>>1
  - 8 ASR: A>>>1
  - 9 PASS: B
  - 10 INC: B+1
  - 11 MUL: low 16 bits of A*B, unsigned
  - 12–15 reserved: result 0, flags 0
- States: IDLE, MUL.
  - IDLE with `start`=1 and op≠MUL: compute, register result and flags, pulse `done`; stay in IDLE.
  - IDLE with `start`=1 and op=MUL: latch A and B, clear accumulator and counter, go to MUL.
  - MUL: one shift-add iteration per cycle, counter 0..15. On the edge at counter=15, register the result, pulse `done`, return to IDLE.
- Flags:
  - N = result[15].
  - Zf = (result == 0).
  - C: carry out for ADD, SUB and INC (SUB: C=1 means no borrow). Shifted-out bit for SHL, SHR and ASR. For MUL, OR of product bits [31:16]. 0 for all other ops.
  - V: signed overflow for ADD and SUB; 0 for all other ops.
- `from_ALU` and `flags` hold their value between `done` pulses.
- `start` while `busy`=1 is ignored; no queuing.
- Reset (`reset`=0 on an edge), including mid-MUL:
  - state IDLE, counter 0
  - `from_ALU`=0, `flags`=0, `busy`=0, `done`=0
  - any in-flight multiply is discarded

## Timing
- Single-cycle op, `start` sampled at edge E0: result, flags and `done`=1 are valid after E0, for one cycle. Latency 1.
- MUL, `start` sampled at E0:
  - `busy`=1 after E0 through E15.
  - Iterations on edges E1..E16.
  - Result, flags and `done`=1 valid after E16; `busy`=0 in the same cycle.
- A new `start` is accepted in the `done` cycle; back-to-back operations are allowed.
- The control unit asserts `Z_in` in the `done` cycle. The Z register captures `from_ALU` on the following edge.

## Configuration
- `ALU_MUL_EN` defined: the MUL state, counter and multiplier are compiled in; opcode 11 behaves as described above.
- `ALU_MUL_EN` undefined:
  - opcode 11 is treated as reserved: result 0, flags 0, `done` after 1 cycle
  - `busy` is tied to 0
  - no MUL state exists

## Structure
- Shared package `alu_pkg`:
  - `WIDTH` constant
  - opcode enum (`OP_ADD` … `OP_MUL`)
  - state enum (`S_IDLE`, `S_MUL`)
  - flag bit index constants
- Sub-module `alu_mul_seq`: shift-add multiplier with start/done, instantiated only under `ALU_MUL_EN`.

## Test plan
- ADD: A=0x7FFF, B=0x0001 -> `from_ALU`=0x8000, N=1, Zf=0, C=0, V=1; `done` in the cycle after `start`.
- SUB: A=0x0005, B=0x0005 -> 0x0000, Zf=1, C=1, V=0. SUB: A=0x0000, B=0x0001 -> 0xFFFF, N=1, C=0.
- MUL: A=0x0123, B=0x0010 -> 0x1230, C=0; `busy` high for exactly 16 cycles, `done` 16 cycles after the start edge; a second `start` (op ADD) at cycle 5 is ignored.
- MUL: A=0x1000, B=0x0100 -> 0x0000, Zf=1, C=1.
- Drive `reset`=0 at the 8th MUL cycle -> next cycle `busy`=0, `done`=0, `from_ALU`=0, `flags`=0. A following ADD 2+3 -> 0x0005.
- Build without `ALU_MUL_EN`: opcode 11 with A=3, B=4 -> 0x0000, flags 0, `done` after 1 cycle, `busy` never asserted.
